mmio_interconnect: RTL

Parametrised memory-mapped I/O interconnect between the multicycle CPU bus and N peripheral slaves (BRAM, GPIO, UART, ...).
- Replaces the fixed two-way compare/mux and free-running delayed-address register with a table-driven decoder and a registered per-transaction slave select.
- Adds a request/ready handshake, so slow slaves can stall the CPU.
- Unmapped accesses and timeouts return an error response and are recorded in sticky error status.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_addr_decode.sv | 27 ++
 rtl/mmio_interconnect.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types and constants for the MMIO interconnect
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int MMIO_DW = 32;
    localparam logic [MMIO_DW-1:0] MMIO_ERR_RDATA = 32'hDEAD_BEEF;
    localparam int MAX_SLAVES = 16;

    // Keeps slave indices at least one bit wide so a single-slave build still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// rtl/mmio_addr_decode.sv - table-driven address decoder, lowest matching index wins
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int N_SLAVES = 3,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'hFFFF_FFF4, 32'hFFFF_FFF0, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SLAVE_TOP  = {32'hFFFF_FFF7, 32'hFFFF_FFF3, 32'h0000_01FF},
    localparam int IW = idx_width(N_SLAVES)
) (
    input  logic [MMIO_DW-1:0] addr_i,
    output logic               hit_o,
    output logic [IW-1:0]      idx_o
);

    // Scanning from the top down lets the lowest matching index overwrite any higher one.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (addr_i >= SLAVE_BASE[i*32 +: 32] && addr_i <= SLAVE_TOP[i*32 +: 32]) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_interconnect.sv
// rtl/mmio_interconnect.sv - CPU-to-N-slave MMIO interconnect with ready handshake and sticky errors
// Optional slave timeout compiled in with MMIO_TIMEOUT_EN.
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int N_SLAVES = 3,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'hFFFF_FFF4, 32'hFFFF_FFF0, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SLAVE_TOP  = {32'hFFFF_FFF7, 32'hFFFF_FFF3, 32'h0000_01FF}
`ifdef MMIO_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        m_req,
    input  logic [MMIO_DW-1:0]          m_addr,
    input  logic [MMIO_DW-1:0]          m_wdata,
    input  logic                        m_we,
    input  logic [3:0]                  m_byte_mask,
    output logic [MMIO_DW-1:0]          m_rdata,
    output logic                        m_ready,
    output logic                        m_err,
    output logic [N_SLAVES-1:0]         s_sel,
    output logic [MMIO_DW-1:0]          s_addr,
    output logic [MMIO_DW-1:0]          s_wdata,
    output logic                        s_we,
    output logic [3:0]                  s_byte_mask,
    input  logic [N_SLAVES*MMIO_DW-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]         s_ready,
    output logic                        err_sticky,
    output logic [MMIO_DW-1:0]          err_addr,
    input  logic                        err_clear
);

    localparam int IW = idx_width(N_SLAVES);

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic [N_SLAVES-1:0]  s_sel_q;
    logic [MMIO_DW-1:0]   s_addr_q, s_wdata_q, m_rdata_q;
    logic [3:0]           s_mask_q;
    logic                 s_we_q, m_ready_q, m_err_q;
    logic                 err_sticky_q, err_sticky_d;
    logic [MMIO_DW-1:0]   err_addr_q, err_addr_d;

    logic                 dec_hit;
    logic [IW-1:0]        dec_idx;
    logic                 sel_ready;
    logic [MMIO_DW-1:0]   sel_rdata;
    logic                 timeout_ev;
    logic                 err_ev;
    logic [MMIO_DW-1:0]   err_ev_addr;

    mmio_addr_decode #(
        .N_SLAVES   (N_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_TOP  (SLAVE_TOP)
    ) u_decode (
        .addr_i (m_addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    // Only the slave captured at request time may complete the transaction.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == IW'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i*MMIO_DW +: MMIO_DW];
            end
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt_q;

    // ACCESS is only entered from IDLE, so clearing outside ACCESS restarts the count per transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign timeout_ev = (state_q == ACCESS) && !sel_ready && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_ev = 1'b0;
`endif

    assign err_ev      = ((state_q == IDLE) && m_req && !dec_hit) || timeout_ev;
    assign err_ev_addr = (state_q == IDLE) ? m_addr : s_addr_q;

    // A new error outranks a simultaneous clear and then becomes the recorded address.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        if (err_ev) begin
            err_sticky_d = 1'b1;
            if (!err_sticky_q || err_clear) begin
                err_addr_d = err_ev_addr;
            end
        end else if (err_clear) begin
            err_sticky_d = 1'b0;
            err_addr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            s_sel_q   <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_we_q    <= 1'b0;
            s_mask_q  <= '0;
            m_rdata_q <= '0;
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_req && dec_hit) begin
                        idx_q     <= dec_idx;
                        s_sel_q   <= N_SLAVES'(1) << dec_idx;
                        s_addr_q  <= m_addr;
                        s_wdata_q <= m_wdata;
                        s_we_q    <= m_we;
                        s_mask_q  <= m_byte_mask;
                        state_q   <= ACCESS;
                    end else if (m_req) begin
                        m_rdata_q <= '0;
                        m_ready_q <= 1'b1;
                        m_err_q   <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                ACCESS: begin
                    if (sel_ready || timeout_ev) begin
                        m_rdata_q <= sel_ready ? sel_rdata : MMIO_ERR_RDATA;
                        m_ready_q <= 1'b1;
                        m_err_q   <= !sel_ready;
                        s_sel_q   <= '0;
                        s_we_q    <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    m_ready_q <= 1'b0;
                    m_err_q   <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_rdata     = m_rdata_q;
    assign m_ready     = m_ready_q;
    assign m_err       = m_err_q;
    assign s_sel       = s_sel_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_we        = s_we_q;
    assign s_byte_mask = s_mask_q;
    assign err_sticky  = err_sticky_q;
    assign err_addr    = err_addr_q;

endmodule
